// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch resolver and its prediction FIFO.
package branch_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_PENALTY = 2;
    localparam int DEF_CNT_W   = 16;

    // Index width for a table of 'depth' entries; never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Prediction, resolution and training signals between predictor, execute and resolver.
interface branch_resolver_if #(
    parameter int DEPTH = branch_pkg::DEF_DEPTH,
    parameter int CNT_W = branch_pkg::DEF_CNT_W
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic             flush;
    logic             upd_valid;
    logic             upd_taken;
    logic             mispredict;
    logic             underflow;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken, flush,
        input  pred_ready, res_ready, upd_valid, upd_taken, mispredict,
               underflow, occupancy, hit_cnt, miss_cnt
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken, flush,
        output pred_ready, res_ready, upd_valid, upd_taken, mispredict,
               underflow, occupancy, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/pred_fifo.sv
// DEPTH x 1 in-order store of predicted directions; clear outranks push and pop.
module pred_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           push,
    input  logic           pop,
    input  logic           din,
    output logic           dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr];

    // NOTE: storage carries no reset; entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Pairs queued predictions with execute outcomes, trains the predictor and
// stalls new predictions for PENALTY cycles after a mispredict.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PENALTY = DEF_PENALTY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst_n,
    branch_resolver_if.slave bus
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int PEN_W = ptr_width(PENALTY + 1);
    localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(PENALTY);

    state_e           state_q, state_d;
    logic [PEN_W-1:0] pen_q, pen_d;
    logic             full, empty, head;
    logic [PTR_W:0]   count;
    logic             push_fire, pop_fire, miss;
    logic [CNT_W-1:0] hit_q, miss_q;
    logic             upd_valid_q, upd_taken_q, mispredict_q, underflow_q;

    assign bus.pred_ready = !full && (state_q == RUN);
    assign bus.res_ready  = !empty;

    // A flush swallows any same-cycle pop, so no training or statistics follow it.
    assign push_fire = bus.pred_valid && bus.pred_ready;
    assign pop_fire  = bus.res_valid && !empty && !bus.flush;
    assign miss      = pop_fire && (bus.res_taken != head);

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.flush || miss),
        .push  (push_fire),
        .pop   (pop_fire),
        .din   (bus.pred_taken),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.occupancy = count;

    // NOTE: next-state values take their hold defaults first so no path leaves them unassigned.
    always_comb begin
        state_d = state_q;
        pen_d   = pen_q;
        if (bus.flush) begin
            state_d = RUN;
            pen_d   = '0;
        end else if (miss) begin
            state_d = RECOVER;
            pen_d   = PEN_LOAD;
        end else if (state_q == RECOVER) begin
            if (pen_q <= PEN_W'(1)) begin
                state_d = RUN;
                pen_d   = '0;
            end else begin
                pen_d = pen_q - 1'b1;
            end
        end
    end

    // NOTE: all registered state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pen_q   <= '0;
        end else begin
            state_q <= state_d;
            pen_q   <= pen_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            upd_valid_q  <= pop_fire;
            upd_taken_q  <= pop_fire && bus.res_taken;
            mispredict_q <= miss;
            underflow_q  <= underflow_q || (bus.res_valid && empty);
            if (pop_fire && !miss && (hit_q != {CNT_W{1'b1}})) hit_q  <= hit_q + 1'b1;
            if (miss && (miss_q != {CNT_W{1'b1}}))             miss_q <= miss_q + 1'b1;
        end
    end

    assign bus.upd_valid  = upd_valid_q;
    assign bus.upd_taken  = upd_taken_q;
    assign bus.mispredict = mispredict_q;
    assign bus.underflow  = underflow_q;
    assign bus.hit_cnt    = hit_q;
    assign bus.miss_cnt   = miss_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and random checks of branch_resolver against a queue-based behavioural model.
module tb_branch_resolver;

    localparam int DEPTH   = 4;
    localparam int PENALTY = 2;
    localparam int CNT_W   = 2;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    branch_resolver_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    branch_resolver #(.DEPTH(DEPTH), .PENALTY(PENALTY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: in-flight predictions, remaining stall cycles, statistics and last-edge outputs.
    bit mq[$];
    int m_stall, m_hit, m_miss;
    bit m_under, m_uv, m_ut, m_mp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit er_p, er_r;
        er_p = (mq.size() < DEPTH) && (m_stall == 0);
        er_r = (mq.size() > 0);
        check("pred_ready", 32'(bus.pred_ready), 32'(er_p));
        check("res_ready",  32'(bus.res_ready),  32'(er_r));
        check("occupancy",  32'(bus.occupancy),  32'(mq.size()));
        check("upd_valid",  32'(bus.upd_valid),  32'(m_uv));
        check("upd_taken",  32'(bus.upd_taken),  32'(m_ut));
        check("mispredict", 32'(bus.mispredict), 32'(m_mp));
        check("underflow",  32'(bus.underflow),  32'(m_under));
        check("hit_cnt",    32'(bus.hit_cnt),    32'(m_hit));
        check("miss_cnt",   32'(bus.miss_cnt),   32'(m_miss));
    endtask

    task automatic model_reset();
        mq.delete();
        m_stall = 0; m_hit = 0; m_miss = 0;
        m_under = 0; m_uv = 0; m_ut = 0; m_mp = 0;
    endtask

    // Reset asserted mid-cycle: outputs must return to reset values without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.pred_valid = 0; bus.pred_taken = 0;
        bus.res_valid = 0; bus.res_taken = 0; bus.flush = 0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model, cross the rising edge.
    task automatic step(input bit pv, input bit pt, input bit rv, input bit rt, input bit fl);
        bit push, pop;
        bus.pred_valid = pv; bus.pred_taken = pt;
        bus.res_valid = rv;  bus.res_taken = rt;
        bus.flush = fl;
        #1;
        check_all();
        push = pv && (mq.size() < DEPTH) && (m_stall == 0);
        pop  = rv && (mq.size() > 0);
        if (rv && mq.size() == 0) m_under = 1;
        if (fl) begin
            mq.delete();
            m_stall = 0;
            m_uv = 0; m_ut = 0; m_mp = 0;
        end else begin
            m_uv = pop;
            m_ut = pop && rt;
            m_mp = 0;
            if (pop && (rt != mq[0])) begin
                if (m_miss < MAXC) m_miss++;
                m_mp = 1;
                mq.delete();
                m_stall = PENALTY;
            end else begin
                if (pop) begin
                    if (m_hit < MAXC) m_hit++;
                    void'(mq.pop_front());
                end
                if (push) mq.push_back(pt);
                if (m_stall > 0) m_stall--;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pred_valid = 0; bus.pred_taken = 0;
        bus.res_valid = 0; bus.res_taken = 0; bus.flush = 0;
        #2;
        do_reset();

        // Push T,N,T then resolve T,N,T: three hits, no mispredict.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 1, 0);
        idle(1);
        check("tnt_hit_cnt", 32'(bus.hit_cnt), 32'd3);

        // Fill to DEPTH, fifth push refused, one pop reopens the queue.
        for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 0, 0, 0);
        check("full_occ", 32'(bus.occupancy), 32'(DEPTH));
        check("full_ready", 32'(bus.pred_ready), 32'd0);
        step(0, 0, 1, 1, 0);
        idle(1);
        check("after_pop_occ", 32'(bus.occupancy), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 1, 0);

        // Push T,T,T and resolve N: squash and PENALTY-cycle stall.
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("misp_pulse", 32'(bus.mispredict), 32'd1);
        check("misp_occ", 32'(bus.occupancy), 32'd0);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        check("recover_done", 32'(bus.pred_ready), 32'd1);
        step(0, 0, 1, 1, 0);

        // Resolution with an empty queue sets sticky underflow.
        step(0, 0, 1, 0, 0);
        idle(3);
        check("underflow_sticky", 32'(bus.underflow), 32'd1);

        // Flush with simultaneous push and pop at occupancy 2.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        idle(2);

        // Hit counter saturation at CNT_W=2.
        do_reset();
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        idle(1);
        check("hit_saturated", 32'(bus.hit_cnt), 32'(MAXC));

        // Reset dropped during recovery.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        check("in_recover", 32'(bus.pred_ready), 32'd0);
        do_reset();
        check("reset_ready", 32'(bus.pred_ready), 32'd1);

        // Random traffic with occasional flushes and mid-queue resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
